// File: rtl/sonic_mgmt_pkg.sv
// Shared types and constants for the phy_mgmt requester arbiter.
package sonic_mgmt_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [31:0] ABORT_DATA    = 32'hDEADBEEF;
   localparam int          DEF_ADDR_W    = 9;
   localparam int          DEF_DATA_W    = 32;
   localparam int          TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/sonic_rr_arbiter.sv
// Combinational round-robin picker: the nearest set request after i_ptr wins,
// and i_ptr itself is considered last.
module sonic_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [2:0]         i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [2:0]         o_idx
);

   int w_best;
   int w_dist;

   always_comb begin
      w_best = NUM_REQ + 1;
      w_dist = 0;
      o_idx  = 3'd0;
      o_gnt  = '0;
      // distance measured forward from the pointer, wrapping at NUM_REQ
      for (int j = 0; j < NUM_REQ; j++) begin
         w_dist = (j > int'(i_ptr)) ? (j - int'(i_ptr)) : (j - int'(i_ptr) + NUM_REQ);
         if (i_req[j] && (w_dist < w_best)) begin
            w_best = w_dist;
            o_idx  = 3'(j);
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         o_gnt[j] = (|i_req) && (o_idx == 3'(j));
      end
   end

endmodule

// File: rtl/sonic_mgmt_arbiter.sv
// Shares one phy_mgmt Avalon-MM slave among NUM_REQ masters with round-robin
// arbitration, optional lock for read-modify-write and a per-access timeout.
module sonic_mgmt_arbiter
   import sonic_mgmt_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 1023
) (
   input  logic                      phy_mgmt_clk,
   input  logic                      phy_mgmt_clk_reset,
   input  logic [NUM_REQ*ADDR_W-1:0] s_address,
   input  logic [NUM_REQ-1:0]        s_read,
   input  logic [NUM_REQ-1:0]        s_write,
   input  logic [NUM_REQ*DATA_W-1:0] s_writedata,
   input  logic [NUM_REQ-1:0]        s_lock,
   output logic [DATA_W-1:0]         s_readdata,
   output logic [NUM_REQ-1:0]        s_waitrequest,
   output logic [ADDR_W-1:0]         m_address,
   output logic                      m_read,
   output logic                      m_write,
   output logic [DATA_W-1:0]         m_writedata,
   input  logic [DATA_W-1:0]         m_readdata,
   input  logic                      m_waitrequest,
   output logic [2:0]                grant_idx,
   output logic                      busy,
   output logic                      timeout_pulse,
   output logic [15:0]               timeout_count
);

   localparam int WCNT_W = $clog2(TIMEOUT + 1);

   state_t                   r_state;
   logic [2:0]               r_grant_idx;
   logic [2:0]               r_rr_ptr;
   logic [WCNT_W-1:0]        r_wait_cnt;
   logic                     r_busy;
   logic                     r_timeout_pulse;
   logic [TIMEOUT_CNT_W-1:0] r_timeout_count;

   logic [NUM_REQ-1:0] w_req;
   logic [NUM_REQ-1:0] w_arb_gnt;
   logic [2:0]         w_arb_idx;
   logic               w_arb_any;
   logic [ADDR_W-1:0]  w_g_addr;
   logic [DATA_W-1:0]  w_g_wdata;
   logic               w_g_read;
   logic               w_g_write;
   logic               w_g_lock;
   logic               w_g_req;
   logic               w_in_busy;
   logic               w_abort;
   logic               w_done;
   logic               w_drop;

   function automatic logic [TIMEOUT_CNT_W-1:0] sat_inc(input logic [TIMEOUT_CNT_W-1:0] v);
      return (&v) ? v : (v + TIMEOUT_CNT_W'(1));
   endfunction

   assign w_req = s_read | s_write;

   sonic_rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_rr_arbiter (
      .i_req(w_req),
      .i_ptr(r_rr_ptr),
      .o_gnt(w_arb_gnt),
      .o_idx(w_arb_idx)
   );

   assign w_arb_any = |w_arb_gnt;

   always_comb begin
      w_g_addr  = '0;
      w_g_wdata = '0;
      w_g_read  = 1'b0;
      w_g_write = 1'b0;
      w_g_lock  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_idx == 3'(i)) begin
            w_g_addr  = s_address[i*ADDR_W +: ADDR_W];
            w_g_wdata = s_writedata[i*DATA_W +: DATA_W];
            w_g_read  = s_read[i];
            w_g_write = s_write[i];
            w_g_lock  = s_lock[i];
         end
      end
   end

   assign w_in_busy = (r_state == BUSY);
   assign w_g_req   = w_g_read | w_g_write;
   assign w_abort   = w_in_busy && w_g_req && m_waitrequest && (r_wait_cnt == WCNT_W'(TIMEOUT));
   assign w_done    = w_in_busy && w_g_req && !m_waitrequest;
   assign w_drop    = w_in_busy && !w_g_req;

   // Write wins when a requester raises both strobes.
   assign m_write     = w_in_busy && w_g_write && !w_abort;
   assign m_read      = w_in_busy && w_g_read && !w_g_write && !w_abort;
   assign m_address   = w_in_busy ? w_g_addr : '0;
   assign m_writedata = w_in_busy ? w_g_wdata : '0;
   assign s_readdata  = w_abort ? DATA_W'(ABORT_DATA) : m_readdata;

   always_comb begin
      s_waitrequest = '1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if ((w_done || w_abort) && (r_grant_idx == 3'(i))) begin
            s_waitrequest[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge phy_mgmt_clk or posedge phy_mgmt_clk_reset) begin
      if (phy_mgmt_clk_reset) begin
         r_state         <= IDLE;
         r_grant_idx     <= 3'd0;
         r_rr_ptr        <= 3'(NUM_REQ - 1);
         r_wait_cnt      <= '0;
         r_busy          <= 1'b0;
         r_timeout_pulse <= 1'b0;
         r_timeout_count <= '0;
      end else begin
         r_timeout_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_arb_any) begin
                  r_grant_idx <= w_arb_idx;
                  r_wait_cnt  <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               if (w_abort) begin
                  r_rr_ptr        <= r_grant_idx;
                  r_wait_cnt      <= '0;
                  r_timeout_pulse <= 1'b1;
                  r_timeout_count <= sat_inc(r_timeout_count);
                  r_busy          <= 1'b0;
                  r_state         <= IDLE;
               end else if (w_done) begin
                  r_rr_ptr   <= r_grant_idx;
                  r_wait_cnt <= '0;
                  // a locked completion keeps the grant for the next command
                  if (!w_g_lock) begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end else if (w_drop) begin
                  r_rr_ptr   <= r_grant_idx;
                  r_wait_cnt <= '0;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end else if (m_waitrequest) begin
                  r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign grant_idx     = r_grant_idx;
   assign busy          = r_busy;
   assign timeout_pulse = r_timeout_pulse;
   assign timeout_count = r_timeout_count;

endmodule
